mem_access_unit: RTL and testbench

- Memory-stage front end that sits directly upstream of dmem and is the only block driving dmem's ports.
- Accepts byte, halfword and word load/store requests from the pipeline using a valid/ready handshake.
- Converts each request into word-wide dmem accesses. Sub-word stores become read-modify-write sequences.
- Returns sign- or zero-extended load data, and flags misaligned or illegal requests without touching memory.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mau_lane_align.sv | 53 +++++
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit.
//   - size encodings for req_size
//   - FSM state enum
//   - lane_mask(): byte-lane enables touched by an access of a given size/offset
package mem_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned N_LANES  = 4;
  localparam int unsigned SIZE_W   = 2;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_ISSUE = 3'd3,
    ST_RESP     = 3'd4
  } mau_state_e;

  // Byte lanes covered by an access; illegal size touches nothing.
  function automatic logic [N_LANES-1:0] lane_mask(input logic [SIZE_W-1:0] size,
                                                   input logic [1:0]        offset);
    logic [N_LANES-1:0] mask;
    mask = '0;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering between a dmem word and the pipeline.
//   word_i      : word read from dmem
//   size_i      : access size encoding
//   offset_i    : byte offset within the word (addr[1:0])
//   signed_i    : sign-extend sub-word loads
//   wdata_i     : right-justified store data
//   load_data_o : extracted and extended load result
//   merged_o    : word_i with the addressed lanes replaced by store data
module mau_lane_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic [1:0]        offset_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [N_LANES-1:0] mask;
  logic [DATA_W-1:0]  wdata_rep;

  // Load path: pick the addressed lane(s) and extend.
  always_comb begin
    byte_sel    = word_i[{offset_i, 3'b000} +: 8];
    half_sel    = offset_i[1] ? word_i[31:16] : word_i[15:0];
    load_data_o = word_i;
    case (size_i)
      SZ_BYTE: load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: load_data_o = word_i;
    endcase
  end

  // Store path: replicate store data across lanes so the mask alone selects placement.
  always_comb begin
    mask      = lane_mask(size_i, offset_i);
    wdata_rep = wdata_i;
    case (size_i)
      SZ_BYTE: wdata_rep = {4{wdata_i[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata_i[15:0]}};
      default: wdata_rep = wdata_i;
    endcase
    merged_o = word_i;
    for (int i = 0; i < int'(N_LANES); i++) begin
      if (mask[i]) merged_o[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage front end; sole master of dmem.
// Accepts byte/half/word loads and stores over a valid/ready handshake, turns
// them into word-aligned dmem accesses (sub-word stores as read-modify-write),
// and returns extended load data or an error flag for misaligned/illegal
// requests without touching memory.
//   clk, reset                         : clock, async active-high reset
//   req_valid/req_ready                : request handshake
//   req_write/size/signed/addr/wdata   : request payload
//   resp_valid/resp_rdata/resp_error   : one-cycle completion pulse + result
//   mem_enable/read_write/address/
//   data_in/data_out                   : dmem interface
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_enable,
  output logic                  mem_read_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  // Holds MEM_LATENCY-1 (latency range 1..4).
  localparam int unsigned CNT_W = 2;

  mau_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SIZE_W-1:0]     size_q, size_d;
  logic                  signed_q, signed_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic                  req_err_c;
  logic [DATA_WIDTH-1:0] load_data_c;
  logic [DATA_WIDTH-1:0] merged_c;

  // Steering operates on the live dmem output so the capture edge registers the result directly.
  mau_lane_align u_lane_align (
    .word_i      (mem_data_out),
    .size_i      (size_q),
    .offset_i    (addr_q[1:0]),
    .signed_i    (signed_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data_c),
    .merged_o    (merged_c)
  );

  // Illegal size or misaligned half/word.
  always_comb begin
    req_err_c = 1'b0;
    case (req_size)
      SZ_HALF: req_err_c = req_addr[0];
      SZ_WORD: req_err_c = (req_addr[1:0] != 2'b00);
      SZ_ILL:  req_err_c = 1'b1;
      default: req_err_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic; outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    signed_d     = signed_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_error_d = 1'b0;
    mem_enable_d = 1'b0;
    mem_rw_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          write_d  = req_write;
          wdata_d  = req_wdata;
          if (req_err_c) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d      = ST_WR_ISSUE;
            mem_enable_d = 1'b1;
            mem_rw_d     = 1'b1;
            mem_addr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d  = req_wdata;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_d      = ST_RD_ISSUE;
            mem_enable_d = 1'b1;
            mem_addr_d   = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end

      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
      end

      ST_RD_WAIT: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            state_d      = ST_WR_ISSUE;
            mem_enable_d = 1'b1;
            mem_rw_d     = 1'b1;
            mem_wdata_d  = merged_c;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data_c;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WR_ISSUE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  // State, request and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
      mem_enable_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      mem_enable_q <= mem_enable_d;
      mem_rw_q     <= mem_rw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_error     = resp_error_q;
  assign mem_enable     = mem_enable_q;
  assign mem_read_write = mem_rw_q;
  assign mem_address    = mem_addr_q;
  assign mem_data_in    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural dmem model.
module tb_mem_access_unit;

  localparam int unsigned LAT = 1;
  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_enable, mem_read_write;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_enable(mem_enable), .mem_read_write(mem_read_write),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dmem: synchronous write, read data valid LAT cycles after the enable cycle.
  logic [31:0] dmem    [0:255];
  logic [31:0] rd_pipe [0:LAT-1];
  always @(posedge clk) begin
    if (mem_enable && mem_read_write) dmem[mem_address[9:2]] <= mem_data_in;
    rd_pipe[0] <= (mem_enable && !mem_read_write) ? dmem[mem_address[9:2]] : 32'hDEAD_BEEF;
    for (int i = 1; i < int'(LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_data_out = rd_pipe[LAT-1];

  typedef struct { logic [31:0] rdata; logic err; int lat; int n_en; int acc; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int off; } wr_t;

  exp_t        exp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ref_mem [0:255];
  int          n_checks = 0, n_fail = 0;
  int          cur_acc = 0, last_resp_cyc = 0, en_cnt = 0;
  bit          busy = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic report_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    report_and_finish();
  endtask

  // Monitor: dmem-side traffic and response pulses against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (busy && cyc > cur_acc) chk("ready_low_busy", 32'(req_ready), 32'd0);
        if (mem_enable) begin
          en_cnt++;
          chk("addr_aligned", 32'(mem_address[1:0]), 32'd0);
          if (mem_read_write) begin
            if (wr_q.size() == 0) begin
              chk("unexpected_write", mem_address, 32'hFFFF_FFFF);
            end else begin
              wr_t wexp;
              wexp = wr_q.pop_front();
              chk("wr_addr", mem_address, wexp.addr);
              chk("wr_data", mem_data_in, wexp.data);
              chk("wr_cycle", 32'(cyc - cur_acc), 32'(wexp.off));
            end
          end
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_error", 32'(resp_error), 32'(e.err));
            chk("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("mem_enable_cycles", 32'(en_cnt), 32'(e.n_en));
          end
          en_cnt = 0;
          busy = 1'b0;
          last_resp_cyc = cyc;
        end
      end
    end
  end

  // Drive a request from a negedge; returns at the negedge after acceptance with req_valid still high.
  task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input bit abandon);
    int n;
    exp_t e;
    wr_t wr;
    logic err;
    logic [31:0] word, val, nw;
    int nb, off;
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) timeout_fail("accept_wait");
    cur_acc = cyc;
    busy = 1'b1;
    if (!abandon) begin
      off = int'(a[1:0]);
      err = (sz == X) || (sz == H && a[0]) || (sz == W && off != 0);
      nb  = (sz == B) ? 1 : (sz == H) ? 2 : 4;
      e.acc = cyc; e.rdata = 32'h0; e.err = err;
      if (err) begin
        e.lat = 1; e.n_en = 0;
      end else begin
        word = ref_mem[a[9:2]];
        if (!w) begin
          val = word >> (8 * off);
          if (nb == 1) begin val &= 32'hFF;   if (sg && val[7])  val |= 32'hFFFF_FF00; end
          if (nb == 2) begin val &= 32'hFFFF; if (sg && val[15]) val |= 32'hFFFF_0000; end
          e.rdata = val; e.lat = 2 + int'(LAT); e.n_en = 1;
        end else begin
          nw = word;
          for (int i = 0; i < nb; i++) nw[8*(off+i) +: 8] = wd[8*i +: 8];
          ref_mem[a[9:2]] = nw;
          wr.addr = {a[31:2], 2'b00}; wr.data = nw;
          wr.off  = (nb == 4) ? 1 : 2 + int'(LAT);
          wr_q.push_back(wr);
          e.lat  = (nb == 4) ? 2 : 3 + int'(LAT);
          e.n_en = (nb == 4) ? 1 : 2;
        end
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || wr_q.size() != 0) timeout_fail("drain_wait");
    @(negedge clk);
  endtask

  task automatic req(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    send(w, sz, sg, a, wd, 1'b0);
    req_valid = 1'b0;
    drain();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctrl"}, 32'({req_ready, resp_valid, resp_error, mem_enable, mem_read_write}),
        32'b10000);
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    chk({tag, "_maddr"}, mem_address, 32'h0);
    chk({tag, "_mdin"}, mem_data_in, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Give every word in the test window a known value.
    for (int i = 0; i < 16; i++) req(1'b1, W, 1'b0, 32'(i * 4), $urandom);

    // Word store then word load.
    req(1'b1, W, 1'b0, 32'h0, 32'hA5A5_A5A5);
    req(1'b0, W, 1'b0, 32'h0, 32'h0);

    // Byte store read-modify-write.
    req(1'b1, W, 1'b0, 32'h4, 32'h1234_5678);
    req(1'b1, B, 1'b0, 32'h6, 32'h0000_00EE);
    req(1'b0, W, 1'b0, 32'h4, 32'h0);
    chk("dmem_rmw_word", dmem[1], 32'h12EE_5678);

    // Extension cases.
    req(1'b1, W, 1'b0, 32'h8, 32'h80FF_7F01);
    req(1'b0, B, 1'b1, 32'hA, 32'h0);
    req(1'b0, B, 1'b0, 32'hB, 32'h0);
    req(1'b0, H, 1'b1, 32'h8, 32'h0);
    req(1'b0, H, 1'b1, 32'hA, 32'h0);

    // Error requests.
    req(1'b0, H, 1'b0, 32'h5, 32'h0);
    req(1'b1, W, 1'b0, 32'h6, 32'h1111_2222);
    req(1'b0, X, 1'b0, 32'h0, 32'h0);

    // Reset during the read wait of a byte store.
    req(1'b1, W, 1'b0, 32'h10, 32'hCAFE_F00D);
    send(1'b1, B, 1'b0, 32'h11, 32'h55, 1'b1);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_reset");
    busy = 1'b0;
    en_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("dmem_untouched", dmem[4], 32'hCAFE_F00D);
    req(1'b0, W, 1'b0, 32'h10, 32'h0);

    // Back-to-back with req_valid held high.
    send(1'b0, W, 1'b0, 32'h8, 32'h0, 1'b0);
    send(1'b0, B, 1'b1, 32'h9, 32'h0, 1'b0);
    req_valid = 1'b0;
    chk("b2b_gap", 32'(cur_acc - last_resp_cyc), 32'd1);
    drain();

    // Randomized traffic over the window.
    for (int k = 0; k < 200; k++) begin
      req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          32'($urandom_range(0, 63)), $urandom);
    end

    report_and_finish();
  end

endmodule
